seg_display_ctrl: RTL and testbench

//   Display controller for the calculator's 8-digit 7-segment panel. Accepts a 16-bit

---
 rtl/seg_display_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Calculator 8-digit 7-segment display controller: serial double-dabble binary->BCD
// conversion with a one-deep pending slot, plus a free-running digit scanner.
module seg_display_ctrl #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        neg,
  input  logic        blank_lz,
  output logic        busy,
  output logic        ready,
  output logic [7:0]  led_en,
  output logic [7:0]  led_cx
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t        state, state_nxt;
  logic [15:0]   bin;
  logic [19:0]   bcd, bcd_adj;
  logic          cap_neg;
  logic [3:0]    iter;
  logic          pend_vld, pend_neg;
  logic [15:0]   pend_val;
  logic [19:0]   disp_bcd;
  logic          disp_neg;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    scan_idx;

  // FSM control strobes
  logic          start, shift_en, latch_en, pend_wr, pend_clr;
  logic [15:0]   st_val;
  logic          st_neg;

  function automatic logic [19:0] dd_adj(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h03;
      4'd1:    seg_code = 8'h9F;
      4'd2:    seg_code = 8'h25;
      4'd3:    seg_code = 8'h0D;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h49;
      4'd6:    seg_code = 8'h41;
      4'd7:    seg_code = 8'h1F;
      4'd8:    seg_code = 8'h01;
      4'd9:    seg_code = 8'h19;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  assign bcd_adj = dd_adj(bcd);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    latch_en  = 1'b0;
    pend_wr   = 1'b0;
    pend_clr  = 1'b0;
    st_val    = value;
    st_neg    = neg;
    case (state)
      IDLE: begin
        // A load left in the slot by the LATCH cycle is started here; a fresh load wins.
        if (load) begin
          start    = 1'b1;
          pend_clr = 1'b1;
        end else if (pend_vld) begin
          start    = 1'b1;
          pend_clr = 1'b1;
          st_val   = pend_val;
          st_neg   = pend_neg;
        end
        if (start) state_nxt = CONV;
      end
      CONV: begin
        shift_en = 1'b1;
        pend_wr  = load;
        if (iter == 4'd15) state_nxt = LATCH;
      end
      LATCH: begin
        latch_en = 1'b1;
        if (pend_vld) begin
          // A same-cycle load supersedes the slot, so the newest value is started.
          start     = 1'b1;
          pend_clr  = 1'b1;
          st_val    = load ? value : pend_val;
          st_neg    = load ? neg   : pend_neg;
          state_nxt = CONV;
        end else begin
          pend_wr   = load;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      cap_neg  <= 1'b0;
      iter     <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      pend_neg <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= latch_en;
      if (start) begin
        bin     <= st_val;
        cap_neg <= st_neg;
        bcd     <= '0;
        iter    <= '0;
      end else if (shift_en) begin
        bcd  <= {bcd_adj[18:0], bin[15]};
        bin  <= {bin[14:0], 1'b0};
        iter <= iter + 4'd1;
      end
      if (latch_en) begin
        disp_bcd <= bcd;
        disp_neg <= cap_neg;
      end
      if (pend_clr) begin
        pend_vld <= 1'b0;
      end else if (pend_wr) begin
        pend_vld <= 1'b1;
        pend_val <= value;
        pend_neg <= neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= 3'd7;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx - 3'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // lz[k]: digit k and every higher digit are zero; units never qualifies
  logic [4:0] lz;
  logic [3:0] cur_dig;
  logic [7:0] cx_nxt;

  always_comb begin
    lz[4] = (disp_bcd[19:16] == 4'd0);
    lz[3] = lz[4] && (disp_bcd[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_bcd[11:8]  == 4'd0);
    lz[1] = lz[2] && (disp_bcd[7:4]   == 4'd0);
    lz[0] = 1'b0;
  end

  always_comb begin
    cur_dig = 4'd0;
    cx_nxt  = 8'hFF;
    case (scan_idx)
      3'd7:    cx_nxt = disp_neg ? 8'hFD : 8'hFF;
      3'd6,
      3'd5:    cx_nxt = 8'hFF;
      3'd4:    cur_dig = disp_bcd[19:16];
      3'd3:    cur_dig = disp_bcd[15:12];
      3'd2:    cur_dig = disp_bcd[11:8];
      3'd1:    cur_dig = disp_bcd[7:4];
      default: cur_dig = disp_bcd[3:0];
    endcase
    if (scan_idx <= 3'd4)
      cx_nxt = (blank_lz && lz[scan_idx]) ? 8'hFF : seg_code(cur_dig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_en <= 8'h7F;
      led_cx <= 8'hFF;
    end else begin
      led_en <= ~(8'h01 << scan_idx);
      led_cx <= cx_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: vector table of displayed values plus
// hand-written sequences for reset, pending-load and mid-conversion reset cases.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst, load, neg, blank_lz;
  logic [15:0] value;
  logic        busy, ready;
  logic [7:0]  led_en, led_cx;

  int checks = 0;
  int passed = 0;

  seg_display_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .neg(neg),
    .blank_lz(blank_lz), .busy(busy), .ready(ready), .led_en(led_en), .led_cx(led_cx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic            neg;
    logic            lz;
    logic [7:0][7:0] exp;   // exp[i] = expected led_cx while digit idx i is enabled
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_load(input logic [15:0] v, input logic n);
    @(negedge clk);
    load = 1'b1; value = v; neg = n;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_digit(input int i, input logic [7:0] exp, input string name);
    logic [7:0] tgt;
    bit found;
    tgt = 8'h01 << i;
    tgt = ~tgt;
    found = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (led_en == tgt) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      checks++;
      $display("FAIL %s: digit %0d never enabled, led_en=%0h", name, i, led_en);
    end else begin
      chk(name, led_cx, exp);
    end
  endtask

  initial begin
    int lat, r1, r2, rcnt, busy_gap, err42, saw99;

    vecs[0] = '{16'd1234,  1'b0, 1'b1, {8'hFF,8'hFF,8'hFF,8'hFF,8'h9F,8'h25,8'h0D,8'h99}};
    vecs[1] = '{16'd65535, 1'b0, 1'b1, {8'hFF,8'hFF,8'hFF,8'h41,8'h49,8'h49,8'h0D,8'h49}};
    vecs[2] = '{16'd0,     1'b0, 1'b1, {8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'h03}};
    vecs[3] = '{16'd0,     1'b0, 1'b0, {8'hFF,8'hFF,8'hFF,8'h03,8'h03,8'h03,8'h03,8'h03}};
    vecs[4] = '{16'd5,     1'b1, 1'b1, {8'hFD,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'h49}};
    vecs[5] = '{16'd10800, 1'b0, 1'b1, {8'hFF,8'hFF,8'hFF,8'h9F,8'h03,8'h01,8'h03,8'h03}};
    vecs[6] = '{16'd90,    1'b1, 1'b0, {8'hFD,8'hFF,8'hFF,8'h03,8'h03,8'h03,8'h19,8'h03}};
    vecs[7] = '{16'd500,   1'b0, 1'b1, {8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'h49,8'h03,8'h03}};

    rst = 1'b1; load = 1'b0; value = '0; neg = 1'b0; blank_lz = 1'b1;

    // Reset state, then first scan step after SCAN_DIV cycles
    repeat (2) @(negedge clk);
    chk("rst_led_en", led_en, 8'h7F);
    chk("rst_led_cx", led_cx, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("scan_hold_idx7", led_en, 8'h7F);
    @(negedge clk);
    chk("scan_idx6", led_en, 8'hBF);

    // Table of displayed values
    for (int v = 0; v < 8; v++) begin
      blank_lz = vecs[v].lz;
      do_load(vecs[v].value, vecs[v].neg);
      chk($sformatf("v%0d_busy", v), busy, 1'b1);
      wait_ready(lat);
      chk($sformatf("v%0d_latency", v), lat, 17);
      @(negedge clk);
      chk($sformatf("v%0d_ready_pulse", v), ready, 1'b0);
      for (int i = 7; i >= 0; i--)
        check_digit(i, vecs[v].exp[i], $sformatf("v%0d_idx%0d", v, i));
    end

    // Two loads during CONV: 99 superseded by 7, started straight from LATCH
    blank_lz = 1'b1;
    do_load(16'd42, 1'b0);
    r1 = -1; r2 = -1; rcnt = 0; busy_gap = 0; err42 = 0; saw99 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 4) begin load = 1'b1; value = 16'd99; end
      if (k == 5) value = 16'd7;
      if (k == 6) load = 1'b0;
      @(negedge clk);
      if (ready) begin
        rcnt++;
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      if (k <= 33 && !busy) busy_gap++;
      if (k >= 19 && k <= 34 && led_en == 8'hFE && led_cx != 8'h25) err42++;
      if (led_cx == 8'h19) saw99++;
    end
    chk("pend_ready1_lat", r1, 17);
    chk("pend_ready2_lat", r2, 34);
    chk("pend_ready_count", rcnt, 2);
    chk("pend_busy_gap", busy_gap, 0);
    chk("pend_show42", err42, 0);
    chk("pend_99_hidden", saw99, 0);
    chk("pend_idle", busy, 1'b0);
    check_digit(0, 8'h1F, "pend_idx0");
    check_digit(1, 8'hFF, "pend_idx1");

    // Reset mid-conversion of 500 with a pending load queued
    do_load(16'd500, 1'b0);
    repeat (2) @(negedge clk);
    load = 1'b1; value = 16'd777;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_led_en", led_en, 8'h7F);
    chk("mrst_led_cx", led_cx, 8'hFF);
    rcnt = 0; busy_gap = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) rcnt++;
      if (busy) busy_gap++;
    end
    chk("mrst_no_ready", rcnt, 0);
    chk("mrst_pend_cleared", busy_gap, 0);
    check_digit(0, 8'h03, "mrst_idx0");
    check_digit(1, 8'hFF, "mrst_idx1");
    check_digit(7, 8'hFF, "mrst_idx7");

    do_load(16'd3, 1'b0);
    wait_ready(lat);
    chk("post_rst_latency", lat, 17);
    @(negedge clk);
    check_digit(0, 8'h0D, "post_rst_idx0");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
